// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (ADD, SUB, AND, SLL, SLR) and divide-by-zero results are
// registered on the accept edge. MUL, DIVU and REMU iterate one bit per
// cycle for WIDTH cycles before the result is registered.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     operands and op are presented
//   in_ready     block can accept (IDLE only)
//   in_a, in_b   operands (in_b is also the shift amount)
//   in_op        0 ADD, 1 SUB, 2 AND, 3 SLL, 4 SLR, 5 MUL, 6 DIVU, 7 REMU
//   out_valid    result held valid (DONE)
//   out_ready    consumer accepts result
//   out_result   result, with out_zero / out_negative flags
//   out_div_zero DIVU/REMU issued with in_b == 0
//   busy         state != IDLE
module seq_alu #(
  parameter int WIDTH     = 32,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_div_zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_SLL = 3'd3,
    OP_SLR = 3'd4, OP_MUL = 3'd5, OP_DIVU = 3'd6, OP_REMU = 3'd7
  } op_t;

  state_t           state, state_next;
  logic [2:0]       op_reg;
  logic [CW-1:0]    count;
  // MUL: acc = partial product, work_a = shifted multiplicand, work_b = multiplier
  // DIV: acc = partial remainder, work_a = dividend/quotient, work_b = divisor
  logic [WIDTH-1:0] acc, work_a, work_b;

  logic             accept, b_zero, is_div, iterative, shift_big;
  logic [WIDTH-1:0] quick_result;
  logic [WIDTH-1:0] mul_sum, rem_next, q_next, iter_result;
  logic [WIDTH-1:0] acc_step, work_a_step, work_b_step;
  logic [WIDTH:0]   rem_shift, diff;
  logic             ge;

  assign accept    = in_valid && (state == IDLE);
  assign b_zero    = (in_b == '0);
  assign is_div    = (in_op == OP_DIVU) || (in_op == OP_REMU);
  assign iterative = (in_op == OP_MUL) || (is_div && !b_zero);
  // Power-of-two WIDTH: B >= WIDTH exactly when any bit above the shift field is set.
  assign shift_big = |in_b[WIDTH-1:SW];

  always_comb begin
    quick_result = '0;
    case (in_op)
      OP_ADD:  quick_result = in_a + in_b;
      OP_SUB:  quick_result = in_a - in_b;
      OP_AND:  quick_result = in_a & in_b;
      OP_SLL:  quick_result = shift_big ? '0 : (in_a << in_b[SW-1:0]);
      OP_SLR:  quick_result = shift_big ? '0 : (in_a >> in_b[SW-1:0]);
      OP_DIVU: quick_result = '1;   // only used for divide by zero
      OP_REMU: quick_result = in_a; // only used for divide by zero
      default: quick_result = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring division.
  always_comb begin
    mul_sum   = work_b[0] ? (acc + work_a) : acc;
    rem_shift = {acc, work_a[WIDTH-1]};
    diff      = rem_shift - {1'b0, work_b};
    ge        = ~diff[WIDTH];
    rem_next  = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    q_next    = {work_a[WIDTH-2:0], ge};
    if (op_reg == OP_MUL) begin
      acc_step    = mul_sum;
      work_a_step = work_a << 1;
      work_b_step = work_b >> 1;
      iter_result = mul_sum;
    end else begin
      acc_step    = rem_next;
      work_a_step = q_next;
      work_b_step = work_b;
      iter_result = (op_reg == OP_DIVU) ? q_next : rem_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = iterative ? BUSY : DONE;
      // The last iteration happens on the edge the counter goes 1 -> 0.
      BUSY:    if (count == CW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_reg       <= '0;
      count        <= '0;
      acc          <= '0;
      work_a       <= '0;
      work_b       <= '0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_negative <= 1'b0;
      out_div_zero <= 1'b0;
    end else if (accept) begin
      op_reg <= in_op;
      count  <= CW'(MUL_ITERS);
      acc    <= '0;
      work_a <= in_a;
      work_b <= in_b;
      if (!iterative) begin
        out_result   <= quick_result;
        out_zero     <= (quick_result == '0);
        out_negative <= quick_result[WIDTH-1];
        out_div_zero <= is_div && b_zero;
      end
    end else if (state == BUSY) begin
      count  <= count - CW'(1);
      acc    <= acc_step;
      work_a <= work_a_step;
      work_b <= work_b_step;
      if (count == CW'(1)) begin
        out_result   <= iter_result;
        out_zero     <= (iter_result == '0);
        out_negative <= iter_result[WIDTH-1];
        out_div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [2:0]    in_op;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic          out_zero, out_negative, out_div_zero, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];

  seq_alu #(.WIDTH(W), .MUL_ITERS(W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_negative(out_negative), .out_div_zero(out_div_zero),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one op, push its expected outcome, and scramble inputs after accept.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic dz, input int lat, input string tag);
    exp_t e;
    e.res = res; e.dz = dz; e.lat = lat; e.tag = tag;
    sb.push_back(e);
    @(negedge clock);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
  endtask

  // Wait (bounded) for out_valid, then pop and compare against the scoreboard.
  task automatic collect();
    exp_t e;
    int lat = 1;
    bit hold_ok = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", W'(sb.size()), W'(1));
      return;
    end
    e = sb.pop_front();
    while (out_valid !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
    end
    check({e.tag, "_latency"}, W'(lat), W'(e.lat));
    check({e.tag, "_busy_hold"}, W'(hold_ok), W'(1));
    check({e.tag, "_result"}, out_result, e.res);
    check({e.tag, "_zero"}, W'(out_zero), W'(e.res == '0));
    check({e.tag, "_negative"}, W'(out_negative), W'(e.res[W-1]));
    check({e.tag, "_div_zero"}, W'(out_div_zero), W'(e.dz));
    check({e.tag, "_done_busy"}, W'({busy, in_ready}), W'(2'b10));
    $display("op %s result=%0h z=%0b n=%0b dz=%0b latency=%0d", e.tag, out_result,
             out_zero, out_negative, out_div_zero, lat);
    if (out_ready === 1'b1) begin
      @(posedge clock); #1;
      check({e.tag, "_handshake"}, W'(out_valid), W'(0));
    end
  endtask

  initial begin
    int seen;
    bit stable;
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_busy", W'(busy), W'(0));
    check("reset_result", out_result, '0);
    check("reset_flags", W'({out_zero, out_negative, out_div_zero}), W'(0));
    @(negedge clock); reset = 1'b1;

    // Reset in the middle of a MUL: nothing may come out afterwards.
    @(negedge clock);
    in_a = 7; in_b = 9; in_op = 3'd5; in_valid = 1'b1;
    @(posedge clock); #1; in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2; reset = 1'b0; #1;
    check("midreset_out_valid", W'(out_valid), W'(0));
    check("midreset_in_ready", W'(in_ready), W'(1));
    check("midreset_busy", W'(busy), W'(0));
    @(negedge clock); reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("midreset_no_stale", W'(seen), W'(0));
    $display("reset mid-MUL: stale cycles=%0d", seen);

    // Single-cycle ops
    issue(3'd0, 10, 20, 30, 1'b0, 1, "add");             collect();
    issue(3'd1, 30, 20, 10, 1'b0, 1, "sub");             collect();
    issue(3'd1, 50, 50, 0, 1'b0, 1, "sub_zero");         collect();
    issue(3'd1, 50, 100, 32'hFFFF_FFCE, 1'b0, 1, "sub_neg"); collect();
    issue(3'd2, 32'hF0F, 32'hFFF, 32'hF0F, 1'b0, 1, "and"); collect();

    // Shifts
    issue(3'd3, 32'hF0F, 4, 32'hF0F0, 1'b0, 1, "sll");   collect();
    issue(3'd4, 32'hF0F, 4, 32'hF0, 1'b0, 1, "slr");     collect();
    issue(3'd4, 32'h8000_0000, 31, 1, 1'b0, 1, "slr31"); collect();
    issue(3'd3, 1, 32, 0, 1'b0, 1, "sll32");             collect();
    issue(3'd4, 32'hFFFF_FFFF, 32'h100, 0, 1'b0, 1, "slr_big"); collect();

    // Multi-cycle
    issue(3'd5, 32'h10000, 32'h10001, 32'h10000, 1'b0, W + 1, "mul_trunc"); collect();
    issue(3'd5, 7, 9, 63, 1'b0, W + 1, "mul_small");     collect();
    issue(3'd6, 100, 7, 14, 1'b0, W + 1, "divu");        collect();
    issue(3'd7, 100, 7, 2, 1'b0, W + 1, "remu");         collect();
    issue(3'd6, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, W + 1, "divu_max"); collect();

    // Divide by zero
    issue(3'd6, 5, 0, 32'hFFFF_FFFF, 1'b1, 1, "divu_zero"); collect();
    issue(3'd7, 5, 0, 5, 1'b1, 1, "remu_zero");          collect();

    // Backpressure
    out_ready = 1'b0;
    issue(3'd0, 1, 2, 3, 1'b0, 1, "bp_add");             collect();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = i[0]; in_a = 32'h55; in_b = 32'h66; in_op = 3'd0;
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || out_result !== 32'd3 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", W'(stable), W'(1));
    $display("backpressure hold: stable=%0b", stable);
    @(negedge clock); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_release_valid", W'(out_valid), W'(0));
    check("bp_release_ready", W'(in_ready), W'(1));
    issue(3'd0, 32'hFFFF_FFFF, 1, 0, 1'b0, 1, "b2b_add"); collect();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Keeps the single-cycle ops (add, sub, and, logical shifts) and adds iterative unsigned multiply, divide and remainder.
- Operands enter and results leave through valid/ready handshakes, so the execute stage can stall on long operations.
- Zero and negative flags are registered with the result; a divide-by-zero flag is added.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 4 and a power of two.
- MUL_ITERS, WIDTH, cycles of iterative multiply/divide; fixed at WIDTH (one bit per cycle); parameter exists for lint and documentation only.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; high only in IDLE
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B / shift amount
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 SLL, 4 SLR, 5 MUL, 6 DIVU, 7 REMU
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  result
- out_zero  out  1  out_result == 0
- out_negative  out  1  out_result[WIDTH-1]
- out_div_zero  out  1  DIVU/REMU issued with in_b == 0
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - out_valid, out_result, out_zero, out_negative, out_div_zero, busy all go to 0; in_ready is 1.
  - The iteration counter clears.
  - An operation in flight is discarded; no result is produced after reset releases.
- Accept: an operation is accepted on a rising edge with in_valid && in_ready. in_a, in_b and in_op are latched; later input changes are ignored.
- States:
  - IDLE -> DONE on accept of an op in 0-4, or a DIVU/REMU with B == 0.
  - IDLE -> BUSY on accept of MUL, or DIVU/REMU with B != 0. The counter loads WIDTH.
  - BUSY: one iteration per cycle, counter decrements. Goes to DONE on the cycle the counter reaches 0.
  - DONE: out_valid = 1 and outputs stay stable. Goes to IDLE on out_valid && out_ready.
  - in_ready = (state == IDLE). There is no accept in the same cycle as a DONE handshake; the next op is accepted at the earliest one cycle later.
- Latency, from accept edge to out_valid high:
  - 1 cycle for ops 0-4 and for divide-by-zero.
  - WIDTH+1 cycles for MUL, DIVU and REMU.
- Arithmetic (all results truncated to WIDTH bits):
  - ADD: A + B, modulo 2^WIDTH; carry discarded.
  - SUB: A - B, two's complement.
  - AND: A & B.
  - SLL: A << B. SLR: logical A >> B. If B >= WIDTH, the result is 0; the full B is compared, not a masked B.
  - MUL: shift-add over B's bits, LSB first; the low WIDTH bits of the unsigned product are returned.
  - DIVU: quotient by restoring division, one quotient bit per cycle, MSB first.
  - REMU: remainder from the same restoring division.
  - Divide by zero: DIVU returns all ones, REMU returns A, and out_div_zero = 1. out_div_zero is 0 for every other result.
- Flags: out_zero and out_negative are computed from the final result and registered at the DONE entry edge, together with out_result.
- Backpressure: while out_ready is low, DONE holds indefinitely with all outputs unchanged; in_valid is ignored.

Test Plan:
- Reset/idle: drive reset low mid-BUSY of MUL 7*9, release it -> out_valid stays 0, in_ready = 1, busy = 0, no stale result ever appears.
- Single-cycle ops, WIDTH = 32:
  - ADD 10+20 -> 30, z=0, n=0.
  - SUB 30-20 -> 10.
  - SUB 50-50 -> 0, z=1.
  - SUB 50-100 -> 0xFFFFFFCE, n=1.
  - AND 0xF0F & 0xFFF -> 0xF0F.
  - Each of these has out_valid exactly 1 cycle after accept.
- Shifts:
  - SLL 0xF0F, 4 -> 0xF0F0.
  - SLR 0xF0F, 4 -> 0xF0.
  - SLR 0x80000000, 31 -> 1.
  - SLL 1, 32 -> 0 with z=1.
- Multi-cycle:
  - MUL 0x10000 * 0x10001 -> 0x10000 (truncated); out_valid is 33 cycles after accept.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - busy is high throughout and in_ready low throughout.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF with div_zero=1; REMU 5/0 -> 5 with div_zero=1; both with 1-cycle latency.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles after ADD 1+2 -> result 3 stays stable and in_valid pulses are not accepted.
  - Raise out_ready -> one handshake, then IDLE.
  - A back-to-back ADD is accepted on the following cycle.
